// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag layout.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      OpAdd = 3'd0,
      OpSub = 3'd1,
      OpAnd = 3'd2,
      OpOr  = 3'd3,
      OpXor = 3'd4,
      OpShl = 3'd5,
      OpShr = 3'd6,
      OpMul = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic err;
      logic ovf;
      logic carry;
      logic zero;
   } alu_flags_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Result buffer for alu_pipe: power-of-two circular FIFO with an occupancy count.
// Read data is forced to zero while empty so an idle output port reads as all zeros.
module alu_res_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [DW-1:0]          wdata_i,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [DW-1:0]          rdata_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [DW-1:0]   mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;
   logic            push_en, pop_en;

   // A push into a full FIFO is only taken when the same cycle frees an entry.
   assign pop_en  = pop_i && (count_q != '0);
   assign push_en = push_i && ((count_q != (PtrW+1)'(DEPTH)) || pop_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign valid_o = (count_q != '0);
   assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with credit-based input flow control and an output result FIFO.
// Define ALU_MUL_EN to build the unsigned multiplier for op 7; otherwise op 7 reports err.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ID_W       = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [ALU_OP_W-1:0]   in_op_i,
   input  logic [WIDTH-1:0]      in_a_i,
   input  logic [WIDTH-1:0]      in_b_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [2*WIDTH-1:0]    out_res_o,
   output logic [3:0]            out_flags_o,
   output logic [ID_W-1:0]       out_id_o
);

   localparam int unsigned ResW = 2 * WIDTH;
   localparam int unsigned PayW = ResW + 4 + ID_W;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic              rdy_en_q;
   logic              accept;
   logic [ID_W-1:0]   id_q, id_d;

   logic              s1_v_q;
   alu_op_e           s1_op_q;
   logic [WIDTH-1:0]  s1_a_q, s1_b_q;
   logic [ID_W-1:0]   s1_id_q;

   logic              s2_v_q;
   logic [ResW-1:0]   s2_res_q, res_d;
   alu_flags_t        s2_flags_q, flags_d;
   logic [ID_W-1:0]   s2_id_q;

   logic [WIDTH:0]    sum, diff;
   logic [WIDTH-1:0]  lo;
   logic              fifo_valid;
   logic [PayW-1:0]   fifo_rdata;
   logic [CntW-1:0]   fifo_cnt;
   logic [CntW:0]     inflight;

   // Every accepted op already owns a FIFO slot, so the pipe never has to stall.
   assign inflight   = {1'b0, fifo_cnt} + (CntW+1)'(s1_v_q) + (CntW+1)'(s2_v_q);
   assign in_ready_o = rdy_en_q && (inflight < (CntW+1)'(FIFO_DEPTH));
   assign accept     = in_valid_i && in_ready_o;
   assign id_d       = accept ? id_q + ID_W'(1) : id_q;

`ifdef ALU_MUL_EN
   logic [ResW-1:0] prod;
   assign prod = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
`endif

   always_comb begin
      sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      diff    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      lo      = '0;
      flags_d = '0;
      unique case (s1_op_q)
         OpAdd: begin
            lo            = sum[WIDTH-1:0];
            flags_d.carry = sum[WIDTH];
            flags_d.ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                            (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OpSub: begin
            lo            = diff[WIDTH-1:0];
            flags_d.carry = diff[WIDTH];
            flags_d.ovf   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                            (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OpAnd: lo = s1_a_q & s1_b_q;
         OpOr:  lo = s1_a_q | s1_b_q;
         OpXor: lo = s1_a_q ^ s1_b_q;
         OpShl: lo = s1_a_q << s1_b_q[2:0];
         OpShr: lo = s1_a_q >> s1_b_q[2:0];
`ifdef ALU_MUL_EN
         OpMul: lo = '0;
`else
         OpMul: flags_d.err = 1'b1;
`endif
         default: flags_d.err = 1'b1;
      endcase
      res_d = {{WIDTH{1'b0}}, lo};
`ifdef ALU_MUL_EN
      if (s1_op_q == OpMul) res_d = prod;
`endif
      flags_d.zero = (res_d == '0) && !flags_d.err;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdy_en_q   <= 1'b0;
         id_q       <= '0;
         s1_v_q     <= 1'b0;
         s1_op_q    <= OpAdd;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
         s2_v_q     <= 1'b0;
         s2_res_q   <= '0;
         s2_flags_q <= '0;
         s2_id_q    <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         id_q     <= id_d;
         s1_v_q   <= accept;
         if (accept) begin
            s1_op_q <= alu_op_e'(in_op_i);
            s1_a_q  <= in_a_i;
            s1_b_q  <= in_b_i;
            s1_id_q <= id_q;
         end
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_res_q   <= res_d;
            s2_flags_q <= flags_d;
            s2_id_q    <= s1_id_q;
         end
      end
   end

   alu_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (PayW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (s2_v_q),
      .wdata_i ({s2_res_q, s2_flags_q, s2_id_q}),
      .pop_i   (out_ready_i),
      .valid_o (fifo_valid),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt)
   );

   assign out_valid_o = fifo_valid;
   assign out_res_o   = fifo_rdata[PayW-1 -: ResW];
   assign out_flags_o = fifo_rdata[ID_W +: 4];
   assign out_id_o    = fifo_rdata[ID_W-1:0];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: scoreboard queue filled on accept, drained on output handshake.
module tb_alu_pipe;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flags;
      logic [3:0]  id;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [7:0]  in_a = 8'd0;
   logic [7:0]  in_b = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_res;
   logic [3:0]  out_flags;
   logic [3:0]  out_id;

   exp_t        sb[$];
   logic [3:0]  exp_id = 4'd0;
   int          n_asserts = 0;
   int          n_fail = 0;
   int          n_out = 0;

   always #5 clk = ~clk;

   alu_pipe #(
      .WIDTH      (8),
      .FIFO_DEPTH (4),
      .ID_W       (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_op_i     (in_op),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_res_o   (out_res),
      .out_flags_o (out_flags),
      .out_id_o    (out_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model written from the opcode table, independent of the RTL structure.
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [3:0] id);
      exp_t m;
      int ia, ib, sa, sbv, r;
      bit err, ovf, cy;
      ia = int'(a); ib = int'(b);
      sa  = (ia >= 128) ? ia - 256 : ia;
      sbv = (ib >= 128) ? ib - 256 : ib;
      err = 0; ovf = 0; cy = 0; r = 0;
      case (op)
         3'd0: begin
            r = ia + ib; cy = (r > 255); ovf = (sa + sbv > 127) || (sa + sbv < -128); r = r & 255;
         end
         3'd1: begin
            r = (ia - ib) & 255; cy = (ia < ib); ovf = (sa - sbv > 127) || (sa - sbv < -128);
         end
         3'd2: r = ia & ib;
         3'd3: r = ia | ib;
         3'd4: r = ia ^ ib;
         3'd5: r = (ia << (ib % 8)) & 255;
         3'd6: r = ia >> (ib % 8);
         default: begin
`ifdef ALU_MUL_EN
            r = ia * ib;
`else
            err = 1; r = 0;
`endif
         end
      endcase
      m.res   = r[15:0];
      m.flags = {err, ovf, cy, (r == 0) && !err};
      m.id    = id;
      return m;
   endfunction

   // Monitor: samples on the falling edge, mid-way between driven edges.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            sb.push_back(model(in_op, in_a, in_b, exp_id));
            exp_id = exp_id + 4'd1;
         end
         if (out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (sb.size() == 0) begin
               check("unexpected_output", {out_res, out_flags, out_id}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("scoreboard", {8'h00, out_res, out_flags, out_id}, {8'h00, e});
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bit acc = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
         @(posedge clk); #1;
      end
      check("drain", {31'd0, (sb.size() == 0) && !out_valid}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0;
      sb.delete(); exp_id = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n0;
      bit seen;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_res", {16'd0, out_res}, 32'd0);
      check("rst_out_flags", {28'd0, out_flags}, 32'd0);
      check("rst_out_id", {28'd0, out_id}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // ADD overflow with 3-cycle latency
      send(3'd0, 8'h7F, 8'h01);
      check("lat_c1", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_c2", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_c3", {31'd0, out_valid}, 32'd1);
      check("add_res", {16'd0, out_res}, 32'h0080);
      check("add_flags", {28'd0, out_flags}, 32'h4);
      check("add_id", {28'd0, out_id}, 32'd0);
      wait_drain();

      // SUB borrow and XOR zero, back to back
      send(3'd1, 8'h00, 8'h01);
      send(3'd4, 8'hA5, 8'hA5);
      @(posedge clk); #1;
      check("sub_res", {16'd0, out_res}, 32'h00FF);
      check("sub_flags", {28'd0, out_flags}, 32'h2);
      @(posedge clk); #1;
      check("xor_res", {16'd0, out_res}, 32'h0000);
      check("xor_flags", {28'd0, out_flags}, 32'h1);
      wait_drain();

      // Backpressure: credits cap acceptance at FIFO depth
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_op = 3'(i % 7); in_a = 8'(i * 17 + 3); in_b = 8'(i + 1);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", acc, 32'd4);
      check("bp_ready_low", {31'd0, in_ready}, 32'd0);
      check("hold_res0", {16'd0, out_res}, {16'd0, sb[0].res});
      check("hold_id0", {28'd0, out_id}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_res1", {16'd0, out_res}, {16'd0, sb[0].res});
      check("hold_id1", {28'd0, out_id}, 32'd0);
      out_ready = 1'b1;
      wait_drain();

      // MUL: product when built in, illegal otherwise
      send(3'd7, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      @(posedge clk); #1;
`ifdef ALU_MUL_EN
      check("mul_res", {16'd0, out_res}, 32'hFE01);
      check("mul_flags", {28'd0, out_flags}, 32'h0);
`else
      check("mul_res", {16'd0, out_res}, 32'h0000);
      check("mul_flags", {28'd0, out_flags}, 32'h8);
`endif
      wait_drain();

      // Full-rate stream of 20 ops; IDs wrap through 15 -> 0
      n0 = n_out;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_op = 3'($urandom_range(0, 7));
         in_a  = 8'($urandom_range(0, 255));
         in_b  = 8'($urandom_range(0, 255));
         @(negedge clk);
         check("stream_ready", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk); #1;
      check("stream_rate", n_out - n0, 32'd20);
      wait_drain();

      // Reset with results buffered and in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_op = 3'd3; in_a = 8'(i + 1); in_b = 8'h10;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst = 1'b1;
      sb.delete(); exp_id = 4'd0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_res", {16'd0, out_res}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("no_output_after_rst", {31'd0, seen}, 32'd0);
      @(posedge clk); #1;
      check("ready_after_rst2", {31'd0, in_ready}, 32'd1);

      // First accept after reset restarts IDs at 0
      send(3'd0, 8'hFF, 8'h01);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
